// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

  // Common generator polynomials, including the implicit top coefficient.
  localparam logic [4:0]  CRC4_ITU     = 5'h13;
  localparam logic [8:0]  CRC8_SMBUS   = 9'h107;
  localparam logic [16:0] CRC16_XMODEM = 17'h11021;

endpackage

// File: rtl/crc_bit_step.sv
// Combinational CRC update over BPC serial bits, MSB first, non-reflected.
// The polynomial input excludes the implicit top coefficient.
module crc_bit_step #(
  parameter int WCRC = 8,
  parameter int BPC  = 1
) (
  input  logic [WCRC-1:0] i_crc,
  input  logic [WCRC-1:0] i_poly,
  input  logic [BPC-1:0]  i_bits,
  output logic [WCRC-1:0] o_crc
);

  logic [WCRC-1:0] acc;

  // Unrolled LFSR: each iteration consumes one data bit, highest bit first.
  always_comb begin
    acc = i_crc;
    for (int k = BPC - 1; k >= 0; k--) begin
      acc = {acc[WCRC-2:0], 1'b0} ^ ((acc[WCRC-1] ^ i_bits[k]) ? i_poly : '0);
    end
    o_crc = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Sequential CRC engine over a valid/ready word stream, BPC bits per clock.
// Optional receive-side compare is enabled by defining CRC_CHECK_EN, which
// adds i_crc_rx and o_crc_err.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int              WDATA  = 8,
  parameter int              WCRC   = 8,
  parameter int              BPC    = 1,
  parameter logic [WCRC-1:0] INIT   = '0,
  parameter logic [WCRC-1:0] XOROUT = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [WCRC:0]   i_poly,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [WDATA-1:0] i_data,
  input  logic            i_first,
  input  logic            i_last,
  output logic [WCRC-1:0] o_crc,
  output logic            o_valid
`ifdef CRC_CHECK_EN
  ,
  input  logic [WCRC-1:0] i_crc_rx,
  output logic            o_crc_err
`endif
);

  localparam int STEPS = WDATA / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

  if ((BPC < 1) || ((WDATA % BPC) != 0)) begin : g_bpc_check
    $error("crc_stream_engine: BPC must divide WDATA");
  end

  crc_state_t       state_q, state_d;
  logic [WCRC-1:0]  crc_q, crc_d;
  logic [WCRC-1:0]  poly_q, poly_d;
  logic [WDATA-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WCRC-1:0]  crc_out_q, crc_out_d;
  logic [WCRC-1:0]  crc_step;
`ifdef CRC_CHECK_EN
  logic [WCRC-1:0]  rx_q, rx_d;
  logic             err_q, err_d;
`endif

  // The top polynomial coefficient is always 1 and never stored.
  logic unused_poly_msb;
  assign unused_poly_msb = i_poly[WCRC];

  crc_bit_step #(
    .WCRC(WCRC),
    .BPC (BPC)
  ) u_step (
    .i_crc (crc_q),
    .i_poly(poly_q),
    .i_bits(data_q[WDATA-1 -: BPC]),
    .o_crc (crc_step)
  );

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_crc   = crc_out_q;
`ifdef CRC_CHECK_EN
  assign o_crc_err = err_q;
`endif

  // Next-state logic: accept in IDLE, shift BPC bits per cycle, pulse in DONE.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    poly_d    = poly_q;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    crc_out_d = crc_out_q;
`ifdef CRC_CHECK_EN
    rx_d      = rx_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          data_d  = i_data;
          last_d  = i_last;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
`ifdef CRC_CHECK_EN
          rx_d    = i_crc_rx;
`endif
          if (i_first) begin
            crc_d  = INIT;
            poly_d = i_poly[WCRC-1:0];
          end
        end
      end
      SHIFT: begin
        crc_d  = crc_step;
        data_d = data_q << BPC;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          if (last_q) begin
            state_d   = DONE;
            crc_out_d = crc_step ^ XOROUT;
`ifdef CRC_CHECK_EN
            err_d     = ((crc_step ^ XOROUT) != rx_q);
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; the word shift register and captured rx value need no reset.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
`ifdef CRC_CHECK_EN
    rx_q   <= rx_d;
`endif
    if (i_rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      poly_q    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      crc_out_q <= '0;
`ifdef CRC_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      poly_q    <= poly_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      crc_out_q <= crc_out_d;
`ifdef CRC_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: four instances with different
// widths/rates, table vectors, hand sequences and random frames against a
// polynomial long-division model. Honours CRC_CHECK_EN when defined.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld;
  logic [7:0]  idata;
  logic        ifirst, ilast;
  logic [16:0] ipoly;
  logic [15:0] irx;
  wire  [3:0]  rdy, ov, err;
  wire  [3:0]  crc4;
  wire  [7:0]  crc8, crcx;
  wire  [15:0] crc16;

  int n_checks = 0;
  int n_err    = 0;

  // Per-instance geometry: cycles per word, CRC width, word width, seed, final XOR.
  int          STP[4] = '{4, 8, 2, 4};
  int          WC[4]  = '{4, 8, 16, 8};
  int          WD[4]  = '{4, 8, 8, 8};
  logic [15:0] INI[4] = '{16'h0, 16'h0, 16'h0, 16'h00FF};
  logic [15:0] XO[4]  = '{16'h0, 16'h0, 16'h0, 16'h0055};

  always #5 clk = ~clk;

`ifndef CRC_CHECK_EN
  assign err = 4'b0000;
`endif

  crc_stream_engine #(.WDATA(4), .WCRC(4), .BPC(1), .INIT(4'h0), .XOROUT(4'h0)) u4 (
    .i_clk(clk), .i_rst(rst), .i_poly(ipoly[4:0]), .i_valid(vld[0]), .o_ready(rdy[0]),
    .i_data(idata[3:0]), .i_first(ifirst), .i_last(ilast), .o_crc(crc4), .o_valid(ov[0])
`ifdef CRC_CHECK_EN
    , .i_crc_rx(irx[3:0]), .o_crc_err(err[0])
`endif
  );

  crc_stream_engine #(.WDATA(8), .WCRC(8), .BPC(1), .INIT(8'h0), .XOROUT(8'h0)) u8 (
    .i_clk(clk), .i_rst(rst), .i_poly(ipoly[8:0]), .i_valid(vld[1]), .o_ready(rdy[1]),
    .i_data(idata), .i_first(ifirst), .i_last(ilast), .o_crc(crc8), .o_valid(ov[1])
`ifdef CRC_CHECK_EN
    , .i_crc_rx(irx[7:0]), .o_crc_err(err[1])
`endif
  );

  crc_stream_engine #(.WDATA(8), .WCRC(16), .BPC(4), .INIT(16'h0), .XOROUT(16'h0)) u16 (
    .i_clk(clk), .i_rst(rst), .i_poly(ipoly), .i_valid(vld[2]), .o_ready(rdy[2]),
    .i_data(idata), .i_first(ifirst), .i_last(ilast), .o_crc(crc16), .o_valid(ov[2])
`ifdef CRC_CHECK_EN
    , .i_crc_rx(irx), .o_crc_err(err[2])
`endif
  );

  crc_stream_engine #(.WDATA(8), .WCRC(8), .BPC(2), .INIT(8'hFF), .XOROUT(8'h55)) ux (
    .i_clk(clk), .i_rst(rst), .i_poly(ipoly[8:0]), .i_valid(vld[3]), .o_ready(rdy[3]),
    .i_data(idata), .i_first(ifirst), .i_last(ilast), .o_crc(crcx), .o_valid(ov[3])
`ifdef CRC_CHECK_EN
    , .i_crc_rx(irx[7:0]), .o_crc_err(err[3])
`endif
  );

  function automatic logic [15:0] dut_crc(input int d);
    case (d)
      0:       return {12'h0, crc4};
      1:       return {8'h0, crc8};
      2:       return crc16;
      default: return {8'h0, crcx};
    endcase
  endfunction

  // Reference: remainder of (INIT*x^n + M(x)*x^W) mod P by long division, then XOROUT.
  function automatic logic [15:0] ref_crc(input int w, input int wd, input logic [16:0] poly,
                                          input logic [15:0] init, input logic [15:0] xo,
                                          input logic [7:0] words[$]);
    bit          arr[$];
    int          n;
    logic [15:0] res;
    foreach (words[i])
      for (int k = wd - 1; k >= 0; k--) arr.push_back(words[i][k]);
    n = arr.size();
    for (int i = 0; i < w; i++) arr.push_back(1'b0);
    for (int i = 0; i < w; i++) arr[i] = arr[i] ^ init[w-1-i];
    for (int i = 0; i < n; i++)
      if (arr[i])
        for (int j = 0; j <= w; j++) arr[i+j] = arr[i+j] ^ ((j == 0) ? 1'b1 : poly[w-j]);
    res = '0;
    for (int i = 0; i < w; i++) res[w-1-i] = arr[n+i];
    return res ^ xo;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Offer one word and return at the first sample point after it is accepted.
  task automatic send_word(input int d, input logic [7:0] w, input bit f, input bit l);
    int t;
    t = 0;
    @(negedge clk);
    idata = w; ifirst = f; ilast = l; vld[d] = 1'b1;
    while (!rdy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++; n_err++;
      $display("FAIL handshake_timeout d%0d: ready never rose", d);
    end
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0; ifirst = 1'b0; ilast = 1'b0;
  endtask

  // Send a whole frame, checking busy time per word and the single result pulse.
  task automatic send_frame(input int d, input logic [16:0] poly, input logic [7:0] w[$],
                            input bit use_first, input logic [15:0] rx,
                            output logic [15:0] got, output logic got_err);
    int pulses, low, vcyc;
    bit last;
    pulses = 0; vcyc = 0; got = '0; got_err = 1'b0;
    irx = rx;
    for (int i = 0; i < w.size(); i++) begin
      last  = (i == w.size() - 1);
      ipoly = (i == 0) ? poly : ~poly;
      send_word(d, w[i], use_first && (i == 0), last);
      low = 0;
      while (!rdy[d] && low < 200) begin
        low++;
        if (ov[d]) begin
          pulses++; vcyc = low; got = dut_crc(d); got_err = err[d];
        end
        @(negedge clk);
      end
      chk($sformatf("ready_low d%0d w%0d", d, i), low, STP[d] + (last ? 1 : 0));
    end
    chk($sformatf("valid_pulses d%0d", d), pulses, 1);
    chk($sformatf("valid_latency d%0d", d), vcyc, STP[d] + 1);
  endtask

  typedef struct {
    int          d;
    logic [16:0] poly;
    int          n;
    logic [7:0]  w[9];
    logic [15:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[6];
    logic [7:0]  s9[9];
    logic [7:0]  q[$];
    logic [15:0] got, gotb, exp, rx;
    logic        e;
    int          d, pulses, t;
    logic [16:0] poly;

    for (int i = 0; i < 9; i++) s9[i] = 8'h31 + 8'(i);
    tv[0] = '{d: 0, poly: 17'(CRC4_ITU),     n: 1, w: '{8'hD, 0, 0, 0, 0, 0, 0, 0, 0}, exp: 16'h4};
    tv[1] = '{d: 1, poly: 17'(CRC8_SMBUS),   n: 9, w: s9, exp: 16'hF4};
    tv[2] = '{d: 2, poly: CRC16_XMODEM,      n: 9, w: s9, exp: 16'h31C3};
    tv[3] = '{d: 1, poly: 17'(CRC8_SMBUS),   n: 1, w: '{8'h01, 0, 0, 0, 0, 0, 0, 0, 0}, exp: 16'h07};
    tv[4] = '{d: 0, poly: 17'(CRC4_ITU),     n: 2, w: '{8'h1, 8'h0, 0, 0, 0, 0, 0, 0, 0}, exp: 16'h5};
    tv[5] = '{d: 2, poly: CRC16_XMODEM,      n: 1, w: '{8'h00, 0, 0, 0, 0, 0, 0, 0, 0}, exp: 16'h0};

    rst = 1'b1; vld = '0; idata = '0; ifirst = 1'b0; ilast = 1'b0; ipoly = '0; irx = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ready d%0d", i), rdy[i], 1);
      chk($sformatf("reset_valid d%0d", i), ov[i], 0);
      chk($sformatf("reset_crc d%0d", i), dut_crc(i), 0);
    end
    rst = 1'b0;

    // First word after reset without i_first: poly is zero, seed shifts out.
    q = '{8'hA5};
    send_frame(3, 17'(CRC8_SMBUS), q, 1'b0, 16'h0, got, e);
    chk("nofirst_after_reset", got, 16'h0055);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      q = {};
      for (int j = 0; j < tv[i].n; j++) q.push_back(tv[i].w[j]);
      rx = (i % 2 == 0) ? tv[i].exp : (tv[i].exp ^ 16'h1);
      send_frame(tv[i].d, tv[i].poly, q, 1'b1, rx, got, e);
      chk($sformatf("table_crc %0d", i), got, tv[i].exp);
`ifdef CRC_CHECK_EN
      chk($sformatf("table_err %0d", i), e, (i % 2 != 0));
`endif
    end

    // Back-to-back frames, then a continuation frame without i_first.
    q = {};
    foreach (s9[i]) q.push_back(s9[i]);
    send_frame(1, 17'(CRC8_SMBUS), q, 1'b1, 16'hF4, got, e);
    chk("b2b_frame_a", got, 16'hF4);
    q = '{8'h5A, 8'hC3, 8'h0F};
    send_frame(1, 17'h131, q, 1'b1, 16'h0, gotb, e);
    chk("b2b_frame_b", gotb, ref_crc(8, 8, 17'h131, 16'h0, 16'h0, q));
    q = '{8'h31};
    send_frame(1, 17'h11D, q, 1'b0, 16'h0, got, e);
    chk("continue_no_first", got, ref_crc(8, 8, 17'h131, gotb, 16'h0, q));

    // Reset during SHIFT of byte 5 aborts the frame silently.
    for (int i = 0; i < 5; i++) begin
      ipoly = 17'(CRC8_SMBUS);
      send_word(1, s9[i], i == 0, 1'b0);
      if (i < 4) begin
        t = 0;
        while (!rdy[1] && t < 50) begin @(negedge clk); t++; end
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", rdy[1], 1);
    chk("abort_valid", ov[1], 0);
    chk("abort_crc", dut_crc(1), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin @(negedge clk); if (ov[1]) pulses++; end
    chk("abort_no_pulse", pulses, 0);
    q = {};
    foreach (s9[i]) q.push_back(s9[i]);
    send_frame(1, 17'(CRC8_SMBUS), q, 1'b1, 16'hF4, got, e);
    chk("after_abort_crc", got, 16'hF4);
`ifdef CRC_CHECK_EN
    chk("check_match_err", e, 0);
    send_frame(1, 17'(CRC8_SMBUS), q, 1'b1, 16'hF5, got, e);
    chk("check_mismatch_crc", got, 16'hF4);
    chk("check_mismatch_err", e, 1);
`endif

    // Random frames on all instances.
    for (int r = 0; r < 40; r++) begin
      d = int'($urandom_range(0, 3));
      q = {};
      for (int j = 0; j < int'($urandom_range(1, 5)); j++)
        q.push_back((WD[d] == 4) ? ($urandom() & 8'h0F) : 8'($urandom()));
      poly = 17'($urandom());
      exp  = ref_crc(WC[d], WD[d], poly, INI[d], XO[d], q);
      rx   = ($urandom_range(0, 1) == 1) ? exp : (exp ^ 16'(1 << $urandom_range(0, WC[d] - 1)));
      send_frame(d, poly, q, 1'b1, rx, got, e);
      chk($sformatf("rand_crc %0d d%0d", r, d), got, exp);
`ifdef CRC_CHECK_EN
      chk($sformatf("rand_err %0d d%0d", r, d), e, (exp != rx));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
